// File: rtl/wb_ring_writer.sv
// wb_ring_writer
//   Wishbone classic write master that drains a small input FIFO of 32-bit
//   results into a circular buffer in RAM port B, one word per bus cycle, at
//   BASE_ADDR + 4*wr_ptr. A write that the RAM flags with stall, or that never
//   receives an ack within TIMEOUT cycles, is dropped and latches err_o.
//
//   Stream handshake (s_valid_i / s_ready_o): a word transfers on a rising
//   clock edge where s_valid_i and s_ready_o are both 1. s_ready_o is a
//   registered copy of "FIFO not full" and is 0 while reset is held. The
//   producer may hold or drop s_valid_i freely; s_data_i is only sampled on
//   a transfer edge.

module wb_ring_writer #(
   parameter int unsigned ADDR_WIDTH = 15,
   parameter int unsigned BASE_ADDR  = 'h0000,
   parameter int unsigned RING_WORDS = 16,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned TIMEOUT    = 8
) (
   input  logic                          clk_i,
   input  logic                          rst_n_i,
   // result stream
   input  logic [31:0]                   s_data_i,
   input  logic                          s_valid_i,
   output logic                          s_ready_o,
   // Wishbone classic master (RAM port B)
   output logic [ADDR_WIDTH-1:0]         wb_adr_o,
   output logic [31:0]                   wb_dat_o,
   output logic                          wb_we_o,
   output logic [3:0]                    wb_sel_o,
   output logic                          wb_stb_o,
   output logic                          wb_cyc_o,
   input  logic                          wb_ack_i,
   input  logic                          wb_stall_i,
   // control / status
   input  logic                          clear_i,
   output logic [$clog2(RING_WORDS)-1:0] wr_ptr_o,
   output logic                          irq_o,
   output logic                          err_o
);

   localparam int unsigned PTR_W = $clog2(RING_WORDS);
   localparam int unsigned IDX_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned TMO_W = $clog2(TIMEOUT);

   localparam logic [ADDR_WIDTH-1:0] BASE_A   = ADDR_WIDTH'(BASE_ADDR);
   localparam logic [CNT_W-1:0]      FULL_CNT = CNT_W'(FIFO_DEPTH);
   localparam logic [TMO_W-1:0]      TMO_LAST = TMO_W'(TIMEOUT - 1);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_WRITE = 1'b1
   } state_e;

   // ------------------------------------------------------------------
   // Storage and state
   // ------------------------------------------------------------------
   logic [31:0]           fifo_mem_q [FIFO_DEPTH];
   logic [IDX_W-1:0]      wr_idx_q;
   logic [IDX_W-1:0]      rd_idx_q;
   logic [CNT_W-1:0]      count_q;
   logic [CNT_W-1:0]      count_d;
   logic                  ready_q;

   state_e                state_q;
   logic [PTR_W-1:0]      wr_ptr_q;
   logic [TMO_W-1:0]      tmo_q;
   logic                  err_q;
   logic                  irq_q;
   logic                  cyc_q;
   logic                  stb_q;
   logic                  we_q;
   logic [3:0]            sel_q;
   logic [ADDR_WIDTH-1:0] adr_q;
   logic [31:0]           dat_q;

   logic                  push;
   logic                  pop;
   logic [ADDR_WIDTH-1:0] adr_d;
   logic                  ptr_wraps;

   // Handshake decode, FIFO occupancy update and next ring address
   always_comb begin
      push      = s_valid_i & ready_q & ~clear_i;
      pop       = (state_q == ST_IDLE) & (count_q != '0) & ~clear_i;
      adr_d     = BASE_A + ADDR_WIDTH'({wr_ptr_q, 2'b00});
      ptr_wraps = &wr_ptr_q;
      count_d   = count_q;
      if (clear_i) begin
         count_d = '0;
      end else begin
         case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   // FIFO data array; contents need no reset because count gates every read
   always_ff @(posedge clk_i) begin
      if (push) begin
         fifo_mem_q[wr_idx_q] <= s_data_i;
      end
   end

   // FIFO pointers, occupancy and the registered ready flag
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wr_idx_q <= '0;
         rd_idx_q <= '0;
         count_q  <= '0;
         ready_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         ready_q <= (count_d != FULL_CNT);
         if (clear_i) begin
            wr_idx_q <= '0;
            rd_idx_q <= '0;
         end else begin
            if (push) begin
               wr_idx_q <= wr_idx_q + 1'b1;
            end
            if (pop) begin
               rd_idx_q <= rd_idx_q + 1'b1;
            end
         end
      end
   end

   // Bus FSM with registered Wishbone outputs, ring pointer, irq and error
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q  <= ST_IDLE;
         wr_ptr_q <= '0;
         tmo_q    <= '0;
         err_q    <= 1'b0;
         irq_q    <= 1'b0;
         cyc_q    <= 1'b0;
         stb_q    <= 1'b0;
         we_q     <= 1'b0;
         sel_q    <= 4'h0;
         adr_q    <= '0;
         dat_q    <= '0;
      end else begin
         irq_q <= 1'b0;
         if (clear_i) begin
            // Abandon any bus cycle silently and restart the ring
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            tmo_q    <= '0;
            err_q    <= 1'b0;
            cyc_q    <= 1'b0;
            stb_q    <= 1'b0;
            we_q     <= 1'b0;
            sel_q    <= 4'h0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (pop) begin
                     dat_q   <= fifo_mem_q[rd_idx_q];
                     adr_q   <= adr_d;
                     cyc_q   <= 1'b1;
                     stb_q   <= 1'b1;
                     we_q    <= 1'b1;
                     sel_q   <= 4'hF;
                     tmo_q   <= '0;
                     state_q <= ST_WRITE;
                  end
               end
               ST_WRITE: begin
                  if (wb_ack_i) begin
                     // Drop strobe on the ack edge so the RAM writes once
                     cyc_q    <= 1'b0;
                     stb_q    <= 1'b0;
                     we_q     <= 1'b0;
                     sel_q    <= 4'h0;
                     wr_ptr_q <= wr_ptr_q + 1'b1;
                     irq_q    <= ptr_wraps;
                     state_q  <= ST_IDLE;
                  end else if (wb_stall_i || (tmo_q == TMO_LAST)) begin
                     // Aborted write: word is lost, pointer stays put
                     cyc_q   <= 1'b0;
                     stb_q   <= 1'b0;
                     we_q    <= 1'b0;
                     sel_q   <= 4'h0;
                     err_q   <= 1'b1;
                     state_q <= ST_IDLE;
                  end else begin
                     tmo_q <= tmo_q + 1'b1;
                  end
               end
               default: begin
                  state_q <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign s_ready_o = ready_q;
   assign wb_adr_o  = adr_q;
   assign wb_dat_o  = dat_q;
   assign wb_we_o   = we_q;
   assign wb_sel_o  = sel_q;
   assign wb_stb_o  = stb_q;
   assign wb_cyc_o  = cyc_q;
   assign wr_ptr_o  = wr_ptr_q;
   assign irq_o     = irq_q;
   assign err_o     = err_q;

endmodule

// File: tb/tb_wb_ring_writer.sv
// tb_wb_ring_writer: directed + randomized bench for the ring writer, with a
// registered RAM responder and a word-level model of the ring.

module tb_wb_ring_writer;

   localparam int AW   = 15;
   localparam int BASE = 'h100;
   localparam int RING = 16;
   localparam int FD   = 4;
   localparam int TMO  = 8;
   localparam int PW   = 4;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [31:0]   s_data_i   = '0;
   logic          s_valid_i  = 1'b0;
   logic          s_ready_o;
   logic [AW-1:0] wb_adr_o;
   logic [31:0]   wb_dat_o;
   logic          wb_we_o;
   logic [3:0]    wb_sel_o;
   logic          wb_stb_o;
   logic          wb_cyc_o;
   logic          wb_ack_i   = 1'b0;
   logic          wb_stall_i = 1'b0;
   logic          clear_i    = 1'b0;
   logic [PW-1:0] wr_ptr_o;
   logic          irq_o;
   logic          err_o;

   wb_ring_writer #(
      .ADDR_WIDTH(AW),
      .BASE_ADDR (BASE),
      .RING_WORDS(RING),
      .FIFO_DEPTH(FD),
      .TIMEOUT   (TMO)
   ) dut (
      .clk_i     (clk),
      .rst_n_i   (rst_n),
      .s_data_i  (s_data_i),
      .s_valid_i (s_valid_i),
      .s_ready_o (s_ready_o),
      .wb_adr_o  (wb_adr_o),
      .wb_dat_o  (wb_dat_o),
      .wb_we_o   (wb_we_o),
      .wb_sel_o  (wb_sel_o),
      .wb_stb_o  (wb_stb_o),
      .wb_cyc_o  (wb_cyc_o),
      .wb_ack_i  (wb_ack_i),
      .wb_stall_i(wb_stall_i),
      .clear_i   (clear_i),
      .wr_ptr_o  (wr_ptr_o),
      .irq_o     (irq_o),
      .err_o     (err_o)
   );

   // ---------------- RAM responder ----------------
   // mode 0: ack one cycle after strobe and store; 1: stall flag; 2: silent
   int          mode = 0;
   logic [63:0] got_q[$];

   always @(posedge clk) begin
      wb_ack_i   <= 1'b0;
      wb_stall_i <= 1'b0;
      if (wb_cyc_o && wb_stb_o && !wb_ack_i && !wb_stall_i) begin
         case (mode)
            0: begin
               wb_ack_i <= 1'b1;
               got_q.push_back({32'(wb_adr_o), wb_dat_o});
            end
            1:       wb_stall_i <= 1'b1;
            default: ;
         endcase
      end
   end

   // ---------------- monitors ----------------
   int irq_cnt  = 0;
   int stb_cnt  = 0;
   int cyc_cnt  = 0;
   int nrdy_cnt = 0;
   int bad_ctl  = 0;

   always @(negedge clk) begin
      if (irq_o) irq_cnt++;
      if (wb_stb_o) stb_cnt++;
      if (wb_cyc_o) cyc_cnt++;
      if (s_valid_i && !s_ready_o) nrdy_cnt++;
      if (wb_cyc_o && (wb_sel_o !== 4'hF || wb_we_o !== 1'b1)) bad_ctl++;
   end

   // ---------------- scoreboard / model ----------------
   int          n_tests = 0;
   int          n_fail  = 0;
   logic [63:0] exp_q[$];
   int          got_rd  = 0;
   int          mdl_ptr = 0;
   int          mdl_err = 0;
   int          exp_irq = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Ring semantics: accepted word lands at BASE + 4*ptr, ptr advances mod RING
   task automatic model_word(input logic [31:0] d);
      logic [31:0] a;
      if (mode == 0) begin
         a = 32'((BASE + 4 * mdl_ptr) % (1 << AW));
         exp_q.push_back({a, d});
         mdl_ptr = (mdl_ptr + 1) % RING;
         if (mdl_ptr == 0) exp_irq++;
      end else begin
         mdl_err = 1;
      end
   endtask

   task automatic check_log(input string tag);
      int n;
      n = got_q.size() - got_rd;
      check({tag, "_count"}, 64'(n), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < n; i++) begin
         check({tag, "_word"}, got_q[got_rd + i], exp_q[i]);
      end
      got_rd = got_q.size();
      exp_q.delete();
   endtask

   // ---------------- driver tasks ----------------
   // Leaves s_valid_i high so back-to-back calls stream one word per cycle
   task automatic send_word(input logic [31:0] d);
      int guard = 0;
      s_data_i  = d;
      s_valid_i = 1'b1;
      while (!s_ready_o && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      check("send_handshake", 64'(s_ready_o), 64'd1);
      @(negedge clk);
      model_word(d);
   endtask

   task automatic idle(input int n);
      s_valid_i = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_quiet();
      int low = 0;
      int guard = 0;
      s_valid_i = 1'b0;
      while (low < 4 && guard < 500) begin
         @(negedge clk);
         low = wb_cyc_o ? 0 : low + 1;
         guard++;
      end
      check("quiet_reached", 64'(low >= 4), 64'd1);
   endtask

   task automatic pulse_clear();
      clear_i = 1'b1;
      @(negedge clk);
      clear_i = 1'b0;
      mdl_ptr = 0;
      mdl_err = 0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int base_irq, base_stb, base_cyc, base_nrdy, ptr_before, guard;

      // Reset state while held
      @(negedge clk);
      @(negedge clk);
      check("rst_cyc",   64'(wb_cyc_o),  64'd0);
      check("rst_stb",   64'(wb_stb_o),  64'd0);
      check("rst_we",    64'(wb_we_o),   64'd0);
      check("rst_sel",   64'(wb_sel_o),  64'd0);
      check("rst_adr",   64'(wb_adr_o),  64'd0);
      check("rst_dat",   64'(wb_dat_o),  64'd0);
      check("rst_ready", 64'(s_ready_o), 64'd0);
      check("rst_ptr",   64'(wr_ptr_o),  64'd0);
      check("rst_irq",   64'(irq_o),     64'd0);
      check("rst_err",   64'(err_o),     64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("ready_after_rst", 64'(s_ready_o), 64'd1);

      // Single word
      base_stb = stb_cnt;
      send_word(32'hDEADBEEF);
      wait_quiet();
      check_log("single");
      check("single_stb_cycles", 64'(stb_cnt - base_stb), 64'd2);
      check("single_ptr", 64'(wr_ptr_o), 64'(mdl_ptr));
      check("single_err", 64'(err_o), 64'(mdl_err));

      // RING+1 words from pointer 0: one wrap, last word back at BASE
      pulse_clear();
      check("clear_ptr", 64'(wr_ptr_o), 64'd0);
      base_irq = irq_cnt;
      exp_irq  = 0;
      for (int i = 0; i < RING + 1; i++) begin
         send_word($urandom);
         idle($urandom_range(0, 3));
      end
      wait_quiet();
      check_log("wrap");
      check("wrap_irq_pulses", 64'(irq_cnt - base_irq), 64'(exp_irq));
      check("wrap_ptr", 64'(wr_ptr_o), 64'(mdl_ptr));

      // Back-to-back burst of 8 words into a 4-deep FIFO
      base_nrdy = nrdy_cnt;
      for (int i = 0; i < 8; i++) send_word($urandom);
      wait_quiet();
      check("burst_ready_dropped", 64'(nrdy_cnt != base_nrdy), 64'd1);
      check_log("burst");
      check("burst_ptr", 64'(wr_ptr_o), 64'(mdl_ptr));

      // Random stream with random gaps
      base_irq = irq_cnt;
      exp_irq  = 0;
      for (int i = 0; i < 24; i++) begin
         send_word($urandom);
         if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 4));
      end
      wait_quiet();
      check_log("random");
      check("random_irq_pulses", 64'(irq_cnt - base_irq), 64'(exp_irq));
      check("random_ptr", 64'(wr_ptr_o), 64'(mdl_ptr));

      // Stall abort: word dropped, pointer kept, next word at same slot
      ptr_before = mdl_ptr;
      mode = 1;
      send_word($urandom);
      wait_quiet();
      check("stall_err", 64'(err_o), 64'(mdl_err));
      check("stall_ptr", 64'(wr_ptr_o), 64'(ptr_before));
      mode = 0;
      send_word($urandom);
      wait_quiet();
      check_log("after_stall");
      check("err_sticky", 64'(err_o), 64'd1);
      pulse_clear();
      check("clear_err", 64'(err_o), 64'(mdl_err));
      check("clear_ptr2", 64'(wr_ptr_o), 64'(mdl_ptr));

      // Timeout abort: no ack, no stall
      ptr_before = mdl_ptr;
      send_word($urandom);
      wait_quiet();
      check_log("pre_timeout");
      base_cyc = cyc_cnt;
      mode = 2;
      send_word($urandom);
      wait_quiet();
      check("timeout_cyc_cycles", 64'(cyc_cnt - base_cyc), 64'(TMO));
      check("timeout_err", 64'(err_o), 64'(mdl_err));
      check("timeout_ptr", 64'(wr_ptr_o), 64'(mdl_ptr));
      check_log("timeout");

      // Reset during a write; second word still queued must vanish
      send_word($urandom);
      send_word($urandom);
      s_valid_i = 1'b0;
      guard = 0;
      while (!wb_cyc_o && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      check("cyc_before_reset", 64'(wb_cyc_o), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_cyc", 64'(wb_cyc_o), 64'd0);
      check("async_rst_stb", 64'(wb_stb_o), 64'd0);
      mdl_ptr = 0;
      mdl_err = 0;
      exp_q.delete();
      @(negedge clk);
      check("rst_mid_ptr",   64'(wr_ptr_o),  64'd0);
      check("rst_mid_ready", 64'(s_ready_o), 64'd0);
      check("rst_mid_err",   64'(err_o),     64'd0);
      rst_n = 1'b1;
      mode  = 0;
      @(negedge clk);
      check("rst_mid_ready_back", 64'(s_ready_o), 64'd1);
      base_cyc = cyc_cnt;
      idle(10);
      check("fifo_flushed_no_cyc", 64'(cyc_cnt - base_cyc), 64'd0);
      send_word(32'hA5A5_0001);
      wait_quiet();
      check_log("post_reset");

      check("ctl_while_cyc", 64'(bad_ctl), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Global time bound
   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
